// File: rtl/boot_sequencer.sv
// Boot loader sequencer: holds the CPU in reset, then accepts a framed image
// (header, N payload words, checksum) and writes the payload into instruction ROM.
module boot_sequencer #(
  parameter int          HOLD_CYCLES = 16,
  parameter logic [15:0] MAGIC       = 16'hB007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        rom_wEn,
  output logic [11:0] rom_waddr,
  output logic [31:0] rom_wdata,
  output logic        cpu_reset,
  output logic        loader_ready,
  output logic [12:0] word_count,
  output logic        boot_done,
  output logic        error
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {S_HOLD, S_RUN, S_HDR, S_LOAD, S_CHK, S_ERR} state_t;

  state_t          state, state_nxt;
  logic [HCW-1:0]  hold_cnt;
  logic            load_req_d;
  logic            load_rise;
  logic            restart;
  logic            hold_end;
  logic [12:0]     n_words;
  logic [12:0]     word_cnt;
  logic [31:0]     sum;
  logic            take_hdr;
  logic            take_word;
  logic            chk_pass;
  logic [15:0]     hdr_magic;
  logic [12:0]     hdr_n;
  logic            vld_p1;
  logic [11:0]     waddr_p1;
  logic [31:0]     wdata_p1;
  logic            done_p1;

  function automatic logic header_ok(input logic [15:0] magic, input logic [12:0] n);
    return (magic == MAGIC) && (n != 13'd0) && (n <= 13'd4096);
  endfunction

  assign hdr_magic = word_data[31:16];
  assign hdr_n     = word_data[12:0];
  assign load_rise = load_req && !load_req_d;
  // A request edge anywhere but HOLD (re)starts a load from the header.
  assign restart   = load_rise && (state != S_HOLD);
  assign hold_end  = (hold_cnt == HCW'(HOLD_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    take_hdr  = 1'b0;
    take_word = 1'b0;
    chk_pass  = 1'b0;
    case (state)
      S_HOLD: if (hold_end) state_nxt = S_RUN;
      S_RUN:  if (load_rise) state_nxt = S_HDR;
      S_HDR: begin
        if (restart) state_nxt = S_HDR;
        else if (word_valid) begin
          if (header_ok(hdr_magic, hdr_n)) begin
            take_hdr  = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (restart) state_nxt = S_HDR;
        else if (word_valid) begin
          take_word = 1'b1;
          if (word_cnt + 13'd1 == n_words) state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (restart) state_nxt = S_HDR;
        else if (word_valid) begin
          if (word_data == sum) begin
            chk_pass  = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
      S_ERR:   if (load_rise) state_nxt = S_HDR;
      default: state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_HOLD;
      hold_cnt   <= '0;
      load_req_d <= 1'b0;
      word_cnt   <= '0;
      sum        <= '0;
      vld_p1     <= 1'b0;
      waddr_p1   <= '0;
      wdata_p1   <= '0;
      done_p1    <= 1'b0;
    end else begin
      state      <= state_nxt;
      load_req_d <= load_req;
      hold_cnt   <= (state == S_HOLD && !hold_end) ? hold_cnt + 1'b1 : '0;
      vld_p1     <= take_word;
      done_p1    <= chk_pass;
      if (restart || take_hdr) begin
        word_cnt <= '0;
        sum      <= '0;
      end else if (take_word) begin
        word_cnt <= word_cnt + 13'd1;
        sum      <= sum + word_data;
      end
      // ---- p1: ROM write stage, one cycle after the accepted word
      if (take_word) begin
        waddr_p1 <= word_cnt[11:0];
        wdata_p1 <= word_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_hdr) n_words <= hdr_n;
  end

  assign rom_wEn      = vld_p1;
  assign rom_waddr    = waddr_p1;
  assign rom_wdata    = wdata_p1;
  assign boot_done    = done_p1;
  assign word_count   = word_cnt;
  assign cpu_reset    = (state != S_RUN);
  assign error        = (state == S_ERR);
  assign loader_ready = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, meaning the number of clk cycles cpu_reset stays high before the CPU is released.
REQ-002 The block SHALL have parameter MAGIC, default 16'hB007, meaning the required value of header word bits [31:16].
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-005 load_req  input  1  reload request, synchronous to clk; only its rising edge acts.
REQ-006 word_valid  input  1  one-cycle strobe: word_data holds a complete received word.
REQ-007 word_data  input  32  received word.
REQ-008 rom_wEn  output  1  instruction-memory write enable.
REQ-009 rom_waddr  output  12  instruction-memory write address.
REQ-010 rom_wdata  output  32  instruction-memory write data.
REQ-011 cpu_reset  output  1  high holds the processor in reset.
REQ-012 loader_ready  output  1  high while words are accepted (HDR, LOAD, CHK).
REQ-013 word_count  output  13  payload words written in the current load.
REQ-014 boot_done  output  1  one-cycle pulse when a load's checksum passes.
REQ-015 error  output  1  high while in ERR.

Function
REQ-016 States SHALL be HOLD, RUN, HDR, LOAD, CHK and ERR; cpu_reset SHALL be 0 only in RUN.
REQ-017 HOLD SHALL count HOLD_CYCLES cycles, then go to RUN.
REQ-018 RUN: a load_req rising edge SHALL go to HDR; word_valid SHALL be ignored.
REQ-019 Rising-edge detection of load_req SHALL use a registered previous value cleared by reset.
REQ-020 HDR: on word_valid, the block SHALL go to LOAD when word_data[31:16]==MAGIC and 1<=N<=4096 (N=word_data[12:0]), storing N and clearing word_count and the sum; otherwise it SHALL go to ERR.
REQ-021 LOAD: each word_valid SHALL, on the next cycle, drive rom_wEn=1 for one cycle with rom_waddr=word_count[11:0] (pre-increment) and rom_wdata=word_data.
REQ-022 LOAD: each word_valid SHALL add word_data to a 32-bit sum (mod 2^32) and increment word_count.
REQ-023 The word_valid that makes word_count equal N SHALL move the state to CHK.
REQ-024 word_valid SHALL be accepted on every consecutive cycle with no loss.
REQ-025 CHK: on word_valid, word_data==sum SHALL pulse boot_done and go to HOLD; a mismatch SHALL go to ERR; no ROM write SHALL occur.
REQ-026 ERR: error=1 and cpu_reset=1; word_valid SHALL be ignored; a load_req rising edge SHALL go to HDR.
REQ-027 A load_req rising edge in HDR, LOAD or CHK SHALL abort the load and restart at HDR with word_count and the sum cleared; a ROM write already registered SHALL still complete.
REQ-028 rom_wEn SHALL never assert outside the cycle following an accepted LOAD word.

Reset
REQ-029 While reset is low: state=HOLD, hold counter=0, cpu_reset=1, rom_wEn=0, rom_waddr=0, rom_wdata=0, loader_ready=0, word_count=0, sum=0, boot_done=0, error=0, load_req history=0.
REQ-030 Reset asserted mid-load SHALL abandon the load; after release the block SHALL run HOLD then RUN without further ROM writes.

Verification
REQ-031 Release reset, load_req low -> cpu_reset=1 for exactly 16 cycles, then 0 in RUN.
REQ-032 In RUN, load_req rising edge, then header 0xB0070003, words 0x11,0x22,0x33 and trailer 0x66 -> writes 0:0x11, 1:0x22, 2:0x33; boot_done pulses once; HOLD for 16 cycles, then RUN.
REQ-033 Same load with trailer 0x67 -> error=1, cpu_reset=1, no further writes; a load_req rising edge -> HDR with loader_ready=1.
REQ-034 Header 0xB0070000 or 0xDEAD0004 -> ERR with no ROM write.
REQ-035 N=4096 with word_valid on every cycle -> 4096 writes at addresses 0..4095 in order; word_count=4096; then CHK.
REQ-036 load_req rising edge after two LOAD words, then a fresh load with N=1 -> the new word is written at address 0 and the checksum is that word alone; reset pulsed mid-LOAD -> all outputs take the REQ-029 values immediately.
